// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The packet layout is the decode-side contract: pc in the upper word, instruction in the lower.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

  // Sequential successor; wraps 32'hFFFF_FFFC -> 0 by plain modular arithmetic.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used for both the issued-PC tag queue and the packet queue.
// Flush has priority over push and pop; storage resets so the head reads zero out of reset.
module fetch_fifo #(
  parameter type         T     = logic [31:0],
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  T                push_data,
  input  logic            pop,
  output logic [CntW-1:0] count,
  output T                head
);

  T                mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    (push && !flush) |-> (count_q < CntW'(DEPTH)) || pop);

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
    (pop && !flush) |-> (count_q != '0));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: sequential PC generation, in-order imem requests under a credit
// limit, response buffering, and redirect handling that discards stale in-flight responses.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        valid_out,
  input  logic        ready_out,
  output fetch_pkt_t  data_out
);

  localparam int unsigned CntW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CreditW = CntW + 1;

  logic [31:0]     pc_q, pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic            active_q;

  logic [CntW-1:0]    tag_count, pkt_count;
  logic [31:0]        tag_head;
  fetch_pkt_t         pkt_in, pkt_head;
  logic [CreditW-1:0] credit_used;
  logic               req_fire, resp_drop, pkt_push, pkt_pop;

  // Credit counts buffered packets plus requests still in flight, so a response always has room.
  // active_q keeps the request low while reset is asserted without a path from any input.
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, pkt_count};
  assign imem_req_valid = active_q && (credit_used < CreditW'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_drop = imem_resp_valid && (drop_q != '0);
  assign pkt_push  = imem_resp_valid && !resp_drop && !redirect_valid;
  assign pkt_pop   = valid_out && ready_out;
  assign pkt_in    = '{pc: tag_head, instr: imem_resp_data};

  assign valid_out = (pkt_count != '0);
  assign data_out  = pkt_head;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (req_fire) begin
      pc_d = next_pc(pc_q);
    end
  end

  always_comb begin
    case ({req_fire, imem_resp_valid})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // On redirect every request issued up to and including this cycle is stale, which is
  // exactly the post-update outstanding count.
  always_comb begin
    drop_d = drop_q;
    if (redirect_valid) begin
      drop_d = outstanding_d;
    end else if (resp_drop) begin
      drop_d = drop_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      active_q      <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      active_q      <= 1'b1;
    end
  end

  // Tags are never flushed: stale responses still pop their own tag as they are dropped.
  fetch_fifo #(
    .T     (logic [31:0]),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (imem_resp_valid),
    .count     (tag_count),
    .head      (tag_head)
  );

  fetch_fifo #(
    .T     (fetch_pkt_t),
    .DEPTH (FIFO_DEPTH)
  ) u_pkt_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (pkt_push),
    .push_data (pkt_in),
    .pop       (pkt_pop),
    .count     (pkt_count),
    .head      (pkt_head)
  );

  a_resp_has_owner: assert property (@(posedge clk) disable iff (!reset)
    imem_resp_valid |-> (outstanding_q != '0));

  a_tags_track_outstanding: assert property (@(posedge clk) disable iff (!reset)
    tag_count == outstanding_q);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: an in-order imem model with configurable latency feeds
// the DUT; each scenario checks the packet stream against the expected sequential PC order.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        valid_out;
  logic        ready_out;
  fetch_pkt_t  data_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat_min = 1;
  int lat_max = 1;

  logic [31:0] pend_addr[$];
  int          pend_due[$];

  // Observations of the cycle just completed.
  logic        xfer;
  fetch_pkt_t  xfer_pkt;
  logic        fire;
  logic [31:0] fire_addr;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC   (ResetPc),
    .FIFO_DEPTH (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .valid_out       (valid_out),
    .ready_out       (ready_out),
    .data_out        (data_out)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Called just after a falling edge with inputs set; advances one cycle and drives responses.
  task automatic cycle();
    int lat;
    xfer      = valid_out & ready_out;
    xfer_pkt  = data_out;
    fire      = imem_req_valid & imem_req_ready;
    fire_addr = imem_req_addr;
    if (fire) begin
      lat = $urandom_range(lat_max, lat_min);
      pend_addr.push_back(fire_addr);
      pend_due.push_back(cyc + lat);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic apply_reset();
    reset           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    ready_out       = 1'b1;
    pend_addr.delete();
    pend_due.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0; ready_out = 1'b1;
    #1;
    total++; if (imem_req_valid !== 1'b0) begin bad++;
      $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    total++; if (valid_out !== 1'b0) begin bad++;
      $display("FAIL rst_valid_out: got %b want 0", valid_out); end
    total++; if (imem_req_addr !== ResetPc) begin bad++;
      $display("FAIL rst_req_addr: got %h want %h", imem_req_addr, ResetPc); end
    total++; if (data_out !== 64'h0) begin bad++;
      $display("FAIL rst_data_out: got %h want 0", data_out); end
  endtask

  task automatic test_free_flow();
    fetch_pkt_t got[$];
    int first_cyc = -1;
    apply_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 16; i++) begin
      int c = cyc;
      cycle();
      if (xfer) begin
        if (first_cyc < 0) first_cyc = c;
        got.push_back(xfer_pkt);
      end
    end
    total++; if (first_cyc != 2) begin bad++;
      $display("FAIL free_latency: got cycle %0d want 2", first_cyc); end
    total++; if (got.size() < 4) begin bad++;
      $display("FAIL free_count: got %0d want >=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      total++;
      if (got[i].pc !== 32'(4 * i) || got[i].instr !== mem(32'(4 * i))) begin bad++;
        $display("FAIL free_pkt%0d: got %h/%h want %h/%h", i, got[i].pc, got[i].instr,
                 32'(4 * i), mem(32'(4 * i)));
      end
    end
  endtask

  task automatic test_backpressure();
    fetch_pkt_t got[$];
    int fires = 0;
    apply_reset();
    lat_min = 1; lat_max = 1;
    ready_out = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (fire) fires++;
    end
    total++; if (fires != 2) begin bad++;
      $display("FAIL bp_fires: got %0d want 2", fires); end
    total++; if (imem_req_valid !== 1'b0) begin bad++;
      $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); end
    total++; if (imem_req_addr !== 32'h8) begin bad++;
      $display("FAIL bp_req_addr: got %h want 8", imem_req_addr); end
    total++; if (valid_out !== 1'b1 || data_out.pc !== 32'h0) begin bad++;
      $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=0", valid_out, data_out.pc); end
    ready_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (xfer) got.push_back(xfer_pkt);
    end
    total++; if (got.size() < 3) begin bad++;
      $display("FAIL bp_count: got %0d want >=3", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      total++;
      if (got[i].pc !== 32'(4 * i) || got[i].instr !== mem(32'(4 * i))) begin bad++;
        $display("FAIL bp_pkt%0d: got %h/%h want %h", i, got[i].pc, got[i].instr, 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_inflight();
    fetch_pkt_t got[$];
    int fires = 0;
    logic [31:0] first_req = 32'hFFFF_FFFF;
    logic early_valid = 1'b0;
    apply_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 2; i++) begin
      cycle();
      if (fire) fires++;
    end
    total++; if (fires != 2 || imem_req_valid !== 1'b0) begin bad++;
      $display("FAIL rdi_setup: got fires=%0d req_valid=%b want 2/0", fires, imem_req_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    total++; if (valid_out !== 1'b0) begin bad++;
      $display("FAIL rdi_flushed: got valid_out=%b want 0", valid_out); end
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (fire && first_req === 32'hFFFF_FFFF) first_req = fire_addr;
      if (xfer) got.push_back(xfer_pkt);
      if (i < 3 && xfer) early_valid = 1'b1;
    end
    total++; if (early_valid !== 1'b0) begin bad++;
      $display("FAIL rdi_stale_out: got early packet want none"); end
    total++; if (first_req !== 32'h100) begin bad++;
      $display("FAIL rdi_req_addr: got %h want 100", first_req); end
    total++;
    if (got.size() < 2 || got[0].pc !== 32'h100 || got[0].instr !== mem(32'h100)
        || got[1].pc !== 32'h104) begin bad++;
      $display("FAIL rdi_pkts: got n=%0d pc0=%h want pc0=100 pc1=104", got.size(),
               got.size() > 0 ? got[0].pc : 32'h0);
    end
  endtask

  task automatic test_redirect_collision();
    fetch_pkt_t got[$];
    logic [31:0] first_req = 32'hFFFF_FFFF;
    apply_reset();
    lat_min = 1; lat_max = 1;
    cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    total++; if (!(imem_req_valid && imem_resp_valid)) begin bad++;
      $display("FAIL col_setup: got req_valid=%b resp_valid=%b want 1/1",
               imem_req_valid, imem_resp_valid); end
    cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (fire && first_req === 32'hFFFF_FFFF) first_req = fire_addr;
      if (xfer) got.push_back(xfer_pkt);
    end
    total++; if (first_req !== 32'h200) begin bad++;
      $display("FAIL col_req_addr: got %h want 200", first_req); end
    total++;
    if (got.size() < 2 || got[0].pc !== 32'h200 || got[0].instr !== mem(32'h200)
        || got[1].pc !== 32'h204) begin bad++;
      $display("FAIL col_pkts: got n=%0d pc0=%h want pc0=200 pc1=204", got.size(),
               got.size() > 0 ? got[0].pc : 32'h0);
    end
  endtask

  task automatic test_pc_wrap();
    fetch_pkt_t got[$];
    logic [31:0] want[3];
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
    apply_reset();
    lat_min = 1; lat_max = 2;
    for (int i = 0; i < 3; i++) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (xfer) got.push_back(xfer_pkt);
    end
    total++; if (got.size() < 3) begin bad++;
      $display("FAIL wrap_count: got %0d want >=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++;
      if (got[i].pc !== want[i] || got[i].instr !== mem(want[i])) begin bad++;
        $display("FAIL wrap_pkt%0d: got %h want %h", i, got[i].pc, want[i]); end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] first_req = 32'hFFFF_FFFF;
    apply_reset();
    lat_min = 1; lat_max = 1;
    ready_out = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    total++; if (valid_out !== 1'b1) begin bad++;
      $display("FAIL ar_pre_valid: got %b want 1", valid_out); end
    #2;
    reset = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    total++; if (valid_out !== 1'b0 || imem_req_valid !== 1'b0) begin bad++;
      $display("FAIL ar_clear: got valid_out=%b req_valid=%b want 0/0", valid_out,
               imem_req_valid); end
    total++; if (imem_req_addr !== ResetPc || data_out !== 64'h0) begin bad++;
      $display("FAIL ar_state: got addr=%h data=%h want %h/0", imem_req_addr, data_out,
               ResetPc); end
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (fire && first_req === 32'hFFFF_FFFF) first_req = fire_addr;
    end
    total++; if (first_req !== ResetPc) begin bad++;
      $display("FAIL ar_first_req: got %h want %h", first_req, ResetPc); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc = ResetPc;
    logic [31:0] exp_req = ResetPc;
    int n_xfer = 0;
    apply_reset();
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 600; i++) begin
      logic redir;
      logic [31:0] rpc;
      redir = ($urandom_range(99, 0) < 5);
      rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(3, 0) * 4))
                                         : ($urandom() & 32'hFFFF_FFFC);
      redirect_valid = redir;
      redirect_pc    = rpc;
      ready_out      = ($urandom_range(3, 0) != 0);
      imem_req_ready = ($urandom_range(3, 0) != 0);
      cycle();
      if (xfer) begin
        n_xfer++;
        total++;
        if (xfer_pkt.pc !== exp_pc || xfer_pkt.instr !== mem(exp_pc)) begin bad++;
          $display("FAIL rnd_pkt@%0d: got %h/%h want %h/%h", cyc, xfer_pkt.pc, xfer_pkt.instr,
                   exp_pc, mem(exp_pc));
        end
        exp_pc = next_pc(exp_pc);
      end
      if (fire) begin
        total++;
        if (fire_addr !== exp_req) begin bad++;
          $display("FAIL rnd_req@%0d: got %h want %h", cyc, fire_addr, exp_req); end
        exp_req = next_pc(exp_req);
      end
      if (redir) begin
        exp_pc  = rpc;
        exp_req = rpc;
      end
    end
    redirect_valid = 1'b0;
    total++; if (n_xfer < 60) begin bad++;
      $display("FAIL rnd_progress: got %0d transfers want >=60", n_xfer); end
  endtask

  initial begin
    test_reset();
    test_free_flow();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collision();
    test_pc_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch front end; sits directly upstream of the decode-side skid buffer and feeds it a valid/ready stream of {pc, instr} packets.
- Generates sequential PCs, issues in-order requests to instruction memory, and holds returned instructions in a small FIFO until the consumer accepts them.
- Handles redirects (branch/flush) by reloading the PC, flushing buffered packets and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- FIFO_DEPTH, 2, response FIFO entries; also the cap on buffered plus outstanding requests (power of two, ≥2).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- redirect_valid  in  1  redirect PC this cycle
- redirect_pc  in  32  new fetch PC (word aligned)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  imem accepts request
- imem_req_addr  out  32  request address
- imem_resp_valid  in  1  response valid; always accepted, in order, ≥1 cycle after request
- imem_resp_data  in  32  instruction word
- valid_out  out  1  packet valid to skid buffer
- ready_out  in  1  skid buffer ready
- data_out  out  64  fetch_pkt_t {pc[63:32], instr[31:0]}

Behaviour:
- State: pc, outstanding count, drop count, tag FIFO of issued PCs, and data FIFO (count 0..FIFO_DEPTH).
- Reset (reset=0, asynchronous): pc=RESET_PC, outstanding=0, drop=0, FIFO empty. Outputs: imem_req_valid=0, valid_out=0, imem_req_addr=RESET_PC, data_out=0.
- Request: imem_req_valid = (outstanding + fifo_count < FIFO_DEPTH). It is driven from registers only, so it does not depend on redirect_valid. imem_req_addr=pc. req_fire = imem_req_valid & imem_req_ready.
- On req_fire: the issued pc is pushed to the tag FIFO and pc <= pc+4. The PC wraps 32'hFFFF_FFFC -> 0.
- Response: on imem_resp_valid, outstanding decrements.
  - If drop>0: drop decrements and the data is discarded.
  - Otherwise {tag pc, imem_resp_data} is pushed to the FIFO.
  - The credit rule guarantees the FIFO is never full on a push. A response with outstanding=0 is an assertion failure.
- Output: valid_out = FIFO non-empty, data_out = FIFO head; both are registered/state-derived with no combinational path from inputs. Pop on valid_out & ready_out.
- Minimum latency: request accepted at cycle N, response at N+1, valid_out at N+2.
- Simultaneous push and pop keep the count unchanged. Pop plus response on a full FIFO is impossible by credit.
- Redirect (redirect_valid=1 at edge):
  - pc <= redirect_pc, overriding any req_fire increment.
  - FIFO flushed (count=0, pending push suppressed).
  - drop <= outstanding + req_fire − imem_resp_valid: all requests issued up to and including this cycle are stale.
  - A valid_out/ready_out transfer in the redirect cycle still completes. The consumer flushes on the same redirect.
  - Back-to-back redirects: each recomputes drop from the current outstanding; the last redirect_pc wins.
- Stall: if ready_out=0, the FIFO fills, credit reaches 0 and requests stop. imem_req_addr holds while imem_req_valid=1 and imem_req_ready=0.
- Reset mid-operation: all state clears immediately. Responses arriving after reset deasserts with outstanding=0 are an environment error.

Decomposition:
- fetch_pkg:
  - fetch_pkt_t packed struct {logic [31:0] pc; logic [31:0] instr;}
  - INSTR_BYTES=4
  - default RESET_PC constant
- Sub-module fetch_fifo:
  - synchronous FIFO parameterised on type and depth
  - ports: push, pop, flush, count, head
  - instanced twice: PC tag FIFO and packet FIFO
- Top: PC register, outstanding/drop counters, glue.

Test Plan:
- Free flow: RESET_PC=0, imem 1-cycle latency, ready_out=1 -> packets pc=0,4,8,12 with instr=mem[pc], one per cycle after a 2-cycle start-up.
- Backpressure: ready_out=0 from the first valid -> exactly 2 packets buffered. imem_req_valid drops to 0 with the address held at 8. On ready_out=1, packets pc 0,4,8 appear in order with no loss or duplicate.
- Redirect with in-flight: 3-cycle imem latency, 2 requests outstanding, redirect_pc=32'h100 -> both stale responses dropped, FIFO empty. The next valid_out carries pc=32'h100.
- Redirect in the same cycle as a response and a req_fire -> the response is discarded, drop counts the new request, and the first packet out has pc=redirect_pc.
- PC wrap: redirect_pc=32'hFFFF_FFF8 -> packets pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Async reset mid-stream: reset=0 between clock edges -> valid_out and imem_req_valid go 0 immediately. After release the first request address is RESET_PC.
